// File: rtl/drum_pkg.sv
// Shared fixed-point types and constants for the drum-mesh node update (4.23 signed).
package drum_pkg;

  localparam int unsigned FIX_W  = 27;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned ACC_W  = 30;

  typedef logic signed [FIX_W-1:0] fix_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam fix_t FIX_MAX = 27'h3FFFFFF;
  localparam fix_t FIX_MIN = 27'h4000000;
  localparam fix_t FIX_ONE = 27'h0800000;

  function automatic acc_t sext30(fix_t x);
    return acc_t'({{(ACC_W - FIX_W){x[FIX_W-1]}}, x});
  endfunction

endpackage

// File: rtl/fix_reduce.sv
// Narrows a 30b accumulator to 4.23: saturates when DRUM_NODE_SATURATE_EN is defined,
// otherwise keeps the low 27 bits (two's-complement wrap).
module fix_reduce
  import drum_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [FIX_W-1:0] o_fix
);

`ifdef DRUM_NODE_SATURATE_EN
  // In range only when the bits above the 27b sign all copy the accumulator sign.
  always_comb begin
    o_fix = i_acc[FIX_W-1:0];
    if (!i_acc[ACC_W-1] && (i_acc[ACC_W-2:FIX_W-1] != '0)) begin
      o_fix = FIX_MAX;
    end else if (i_acc[ACC_W-1] && (i_acc[ACC_W-2:FIX_W-1] != '1)) begin
      o_fix = FIX_MIN;
    end
  end
`else
  logic w_unused;
  assign o_fix    = i_acc[FIX_W-1:0];
  assign w_unused = ^i_acc[ACC_W-1:FIX_W];
`endif

endmodule

// File: rtl/signed_mult.sv
// Shared 4.23 x 4.23 -> 4.23 signed multiplier; truncates toward minus infinity.
module signed_mult
  import drum_pkg::*;
(
  input  logic signed [FIX_W-1:0] i_a,
  input  logic signed [FIX_W-1:0] i_b,
  output logic signed [FIX_W-1:0] o_p
);

  logic signed [2*FIX_W-1:0] w_full;
  logic                      w_unused;

  assign w_full   = i_a * i_b;
  assign o_p      = w_full[FRAC_W +: FIX_W];
  assign w_unused = ^{w_full[2*FIX_W-1:FRAC_W+FIX_W], w_full[FRAC_W-1:0]};

endmodule

// File: rtl/drum_node_update.sv
// One-node damped wave-equation update, 3-stage valid/ready pipeline with lock-step stall.
// Optional macro DRUM_NODE_SATURATE_EN selects saturating (vs wrapping) 30b->27b reductions.
module drum_node_update
  import drum_pkg::*;
#(
  parameter int unsigned DAMP_SHIFT = 10,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [FIX_W-1:0] u_n,
  input  logic signed [FIX_W-1:0] u_s,
  input  logic signed [FIX_W-1:0] u_e,
  input  logic signed [FIX_W-1:0] u_w,
  input  logic signed [FIX_W-1:0] u_c,
  input  logic signed [FIX_W-1:0] u_p,
  input  logic signed [FIX_W-1:0] rho,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [FIX_W-1:0] u_next,
  output logic [CNT_W-1:0]        out_count
);

  logic w_en;
  acc_t w_lap, w_lin, w_inner_acc;
  fix_t w_lapq, w_prod, w_inner, w_unext;

  logic r_v1, r_v2, r_v3;
  fix_t r_lapq, r_rho, r_prod, r_unext;
  acc_t r_lin1, r_lin2;
  logic [CNT_W-1:0] r_cnt;

  // A full output stage that is not being taken freezes the whole pipe.
  assign w_en     = !r_v3 || out_ready;
  assign in_ready = w_en;

  assign w_lap = sext30(u_n) + sext30(u_s) + sext30(u_e) + sext30(u_w) - (sext30(u_c) <<< 2);
  assign w_lin = (sext30(u_c) <<< 1) - sext30(u_p) + (sext30(u_p) >>> DAMP_SHIFT);

  fix_reduce u_red_lap (
    .i_acc (w_lap),
    .o_fix (w_lapq)
  );

  signed_mult u_mult (
    .i_a (r_lapq),
    .i_b (r_rho),
    .o_p (w_prod)
  );

  assign w_inner_acc = sext30(r_prod) + r_lin2;

  fix_reduce u_red_inner (
    .i_acc (w_inner_acc),
    .o_fix (w_inner)
  );

  assign w_unext = w_inner - (w_inner >>> DAMP_SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_lapq  <= '0;
      r_rho   <= '0;
      r_lin1  <= '0;
      r_prod  <= '0;
      r_lin2  <= '0;
      r_unext <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_lapq  <= w_lapq;
      r_rho   <= rho;
      r_lin1  <= w_lin;
      r_v2    <= r_v1;
      r_prod  <= w_prod;
      r_lin2  <= r_lin1;
      r_v3    <= r_v2;
      r_unext <= w_unext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_v3 && out_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_v3;
  assign u_next    = r_unext;
  assign out_count = r_cnt;

endmodule

// File: tb/tb_drum_node_update.sv
// Randomised self-checking bench for drum_node_update against an integer reference model.
module tb_drum_node_update;

  localparam int DS = 10;
  localparam int N_STREAM = 66000;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [26:0] u_n, u_s, u_e, u_w, u_c, u_p, rho, u_next;
  logic [15:0] out_count;

  always #5 clk = ~clk;

  drum_node_update dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u_n       (u_n),
    .u_s       (u_s),
    .u_e       (u_e),
    .u_w       (u_w),
    .u_c       (u_c),
    .u_p       (u_p),
    .rho       (rho),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .u_next    (u_next),
    .out_count (out_count)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint exp_q[$];
  int     acc_cyc_q[$];
  int     cyc = 0;
  int     n_acc = 0;
  int     n_hs = 0;
  int     hs_model = 0;
  bit     lat_chk = 1'b0;
  longint last_out = 0;

  task automatic check_eq(string tag, longint got, longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint wrap27(longint x);
    longint y;
    y = x & 64'h7FFFFFF;
    if (y[26]) y = y - 64'h8000000;
    return y;
  endfunction

  function automatic longint reduce27(longint x);
`ifdef DRUM_NODE_SATURATE_EN
    if (x > 64'sh3FFFFFF) return 64'sh3FFFFFF;
    if (x < -64'sh4000000) return -64'sh4000000;
    return x;
`else
    return wrap27(x);
`endif
  endfunction

  function automatic longint golden(longint n, longint s, longint e, longint w,
                                    longint c, longint p, longint r);
    longint lapq, lin, prod, inner;
    lapq  = reduce27(n + s + e + w - 4 * c);
    lin   = 2 * c - p + (p >>> DS);
    prod  = wrap27((lapq * r) >>> 23);
    inner = reduce27(prod + lin);
    return wrap27(inner - (inner >>> DS));
  endfunction

  task automatic set_in(longint n, longint s, longint e, longint w,
                        longint c, longint p, longint r);
    u_n = 27'(n); u_s = 27'(s); u_e = 27'(e); u_w = 27'(w);
    u_c = 27'(c); u_p = 27'(p); rho = 27'(r);
  endtask

  task automatic set_rand();
    set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom_range(0, 32'h0800000));
  endtask

  // Called just after a falling edge with inputs driven; records the coming rising-edge handshakes.
  task automatic step();
    longint e;
    int     a;
    #1;
    if (out_valid && out_ready) begin
      n_hs++;
      hs_model = (hs_model + 1) % 65536;
      check_eq("queue_nonempty", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = acc_cyc_q.pop_front();
        check_eq("u_next", u_next, e);
        last_out = u_next;
        if (lat_chk) check_eq("latency", cyc - a, 3);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(golden(u_n, u_s, u_e, u_w, u_c, u_p, rho));
      acc_cyc_q.push_back(cyc);
      n_acc++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int b = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && b < 100) begin
      step();
      b++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic vec(string tag, longint n, longint s, longint e, longint w,
                     longint c, longint p, longint r, longint want);
    int prev = n_acc;
    lat_chk   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_in(n, s, e, w, c, p, r);
    step();
    check_eq({tag, "_accept"}, n_acc - prev, 1);
    drain();
    check_eq(tag, last_out, want);
    lat_chk = 1'b0;
  endtask

  longint smp[5][7];
  longint hold;
  int     idx, prev, h0, sent, bound;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_u_next", u_next, 0);
    check_eq("rst_out_count", out_count, 0);
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Fill the pipe, then pulse reset mid-cycle; nothing from before may appear.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin
      set_rand();
      step();
    end
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    hs_model  = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      #1;
      check_eq("post_reset_valid", out_valid, 0);
      step();
    end
    vec("zero", 0, 0, 0, 0, 0, 0, 27'h0200000, 0);
    check_eq("zero_count", out_count, 1);

    vec("impulse", 0, 0, 0, 0, 27'h0800000, 0, 27'h0200000, 27'h07FE000);
    vec("prev_term", 0, 0, 0, 0, 0, 27'h0800000, 27'h0200000, wrap27(64'h7803FF8));
`ifdef DRUM_NODE_SATURATE_EN
    vec("overflow", 27'h2000000, 27'h2000000, 27'h2000000, 27'h2000000, 0, 0,
        27'h0800000, 27'h3FF0000);
`else
    vec("overflow", 27'h2000000, 27'h2000000, 27'h2000000, 27'h2000000, 0, 0,
        27'h0800000, 0);
`endif

    // Backpressure: five offered back to back, only three fit.
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 7; k++) smp[i][k] = (k == 6) ? $urandom_range(0, 32'h0800000) : $urandom;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(smp[idx][0], smp[idx][1], smp[idx][2], smp[idx][3], smp[idx][4], smp[idx][5],
             smp[idx][6]);
      prev = n_acc;
      step();
      if (n_acc != prev) idx++;
    end
    check_eq("bp_accepted", idx, 3);
    #1;
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    hold = u_next;
    repeat (3) begin
      step();
      check_eq("bp_stable", u_next, hold);
    end
    out_ready = 1'b1;
    h0 = n_hs;
    for (int i = 0; i < 5; i++) begin
      if (idx < 5) begin
        in_valid = 1'b1;
        set_in(smp[idx][0], smp[idx][1], smp[idx][2], smp[idx][3], smp[idx][4], smp[idx][5],
               smp[idx][6]);
      end else begin
        in_valid = 1'b0;
      end
      prev = n_acc;
      step();
      if (n_acc != prev) idx++;
    end
    check_eq("bp_all_accepted", idx, 5);
    check_eq("bp_drain_rate", n_hs - h0, 5);
    drain();

    // Random stream; half-rate sink at first, then mostly-ready to keep runtime bounded.
    sent  = 0;
    bound = 0;
    in_valid = 1'b1;
    set_rand();
    while (sent < N_STREAM && bound < 200000) begin
      out_ready = (sent < 2000) ? 1'($urandom % 2) : 1'(($urandom % 10) != 0);
      prev = n_acc;
      step();
      bound++;
      if (n_acc != prev) begin
        sent++;
        set_rand();
      end
    end
    check_eq("stream_sent", sent, N_STREAM);
    drain();
    #1;
    check_eq("out_count", out_count, hs_model);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
